fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the main controller and datapath. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a request/valid handshake, and latches it in an instruction register. Presents `op`, `funct3` and `funct7b5` to the controller. Consumes `PCSrc` and the branch/jump target to select the next PC when the core retires the current instruction.

## Interface
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request; held high until the response arrives
- `imem_addr`  out  XLEN  fetch address; equals `PC` whenever `imem_req`=1
- `imem_rvalid`  in  1  response valid; may assert in the same cycle as `imem_req` or any later cycle
- `imem_rdata`  in  32  instruction word; sampled only when `imem_rvalid`=1
- `Advance`  in  1  core has retired the presented instruction
- `PCSrc`  in  1  take `PCTarget` as the next PC; sampled only with `Advance`
- `PCTarget`  in  XLEN  branch/jump target
- `Instr`  out  32  instruction register
- `InstrValid`  out  1  `Instr` holds a valid instruction for the current `PC`
- `PC`  out  XLEN  address of `Instr`
- `PCPlus4`  out  XLEN  `PC`+4, combinational
- `op`  out  7  `Instr[6:0]`
- `funct3`  out  3  `Instr[14:12]`
- `funct7b5`  out  1  `Instr[30]`
- `MisalignTrap`  out  1  present only with `FETCH_MISALIGN_TRAP_EN`

## Operation
- Reset values:
  - `PC`=`RESET_PC`
  - `Instr`=32'h0000_0013 (NOP)
  - `InstrValid`=0, `imem_req`=0, `MisalignTrap`=0
  - state=BOOT
- BOOT: `imem_req`=0. Unconditionally goes to FETCH on the next edge. This guarantees no request is issued in the reset-release cycle.
- FETCH: `imem_req`=1, `imem_addr`=`PC`.
  - On an edge with `imem_rvalid`=1: `Instr`<=`imem_rdata`, `InstrValid`<=1, go to HOLD.
  - Otherwise remain in FETCH with the address stable.
- HOLD: `imem_req`=0. `Instr`, `PC` and `InstrValid` are stable.
  - On an edge with `Advance`=1: `PC`<= `PCSrc` ? `PCTarget` : `PCPlus4`, `InstrValid`<=0, go to FETCH.
- `Advance` outside HOLD is ignored. `PCSrc` and `PCTarget` are don't-care without `Advance`.
- At most one request is outstanding. `imem_rvalid` outside FETCH is ignored.
- PC arithmetic is modulo 2^XLEN: `PC`=FFFF_FFFC with `PCSrc`=0 wraps to 0.
- Reset asserted mid-fetch or mid-hold returns immediately to reset values. Instruction memory shares `reset_n`, so no stale response survives reset.

## Timing
- Minimum 2 cycles per instruction with zero-wait memory:
  - cycle 0 (FETCH): `imem_rvalid`=1
  - cycle 1 (HOLD): `InstrValid`=1; `Advance` here starts the next fetch in cycle 2
- Each memory wait cycle adds one cycle.
- `op`, `funct3`, `funct7b5`, `PCPlus4` are combinational from registers and glitch-free relative to `clk`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - An `Advance` with `PCSrc`=1 and `PCTarget[1:0]`≠0 enters state TRAP.
  - In TRAP: `MisalignTrap`=1, `imem_req`=0, and `PC`/`Instr` keep the faulting instruction. TRAP is left only by reset.
- Macro undefined:
  - The TRAP state and the `MisalignTrap` port are absent.
  - `PCTarget[1:0]` is forced to 2'b00 when loaded.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants
  - `NOP_INSTR` (32'h0000_0013)
  - `fetch_state_t` enum (BOOT, FETCH, HOLD, TRAP)
- One sub-module, `pc_next_logic`: combinational `PCPlus4` and next-PC mux, including alignment masking or misalign detection.
- FSM and registers live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0, memory returning 32'h00500093 with zero wait:
  - cycle after release: `imem_req`=0
  - next cycle: `imem_addr`=0
  - following cycle: `InstrValid`=1, `op`=7'h13, `funct3`=0
- 3-cycle memory latency: `imem_addr` stays stable for 3 cycles, and `InstrValid` rises exactly one edge after `imem_rvalid`.
- `Advance` with `PCSrc`=0 at `PC`=8 → next `imem_addr`=12. With `PCSrc`=1, `PCTarget`=0x40 → next `imem_addr`=0x40.
- `Advance` pulsed during FETCH → ignored; `PC` unchanged. `PC`=FFFF_FFFC with `Advance`, `PCSrc`=0 → next fetch at 0.
- `reset_n` dropped mid-FETCH at `PC`=0x20 → `imem_req`=0, `PC`=`RESET_PC` and `InstrValid`=0 immediately, without waiting for a clock edge.
- With `FETCH_MISALIGN_TRAP_EN`: `PCTarget`=0x42 → `MisalignTrap`=1 and no further requests. Without the macro: the same stimulus → fetch at 0x40.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage: opcode constants, NOP encoding and FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        TRAP
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational PC+4 and next-PC select. FETCH_MISALIGN_TRAP_EN swaps target masking for
// misalignment detection.
module pc_next_logic #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_src_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] pc_next_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    assign pc_plus4_o = pc_i + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign pc_next_o  = pc_src_i ? pc_target_i : pc_plus4_o;
    assign misalign_o = pc_src_i && (pc_target_i[1:0] != 2'b00);
`else
    // Low two bits are dropped so a bad target can never produce a misaligned fetch.
    assign pc_next_o  = pc_src_i ? (pc_target_i & ~XLEN'(3)) : pc_plus4_o;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, request/valid fetch handshake and instruction register.
// Optional misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            Advance,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [31:0]     Instr,
    output logic            InstrValid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            MisalignTrap
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_next;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign;
`endif

    pc_next_logic #(
        .XLEN (XLEN)
    ) u_pc_next (
        .pc_i        (pc_q),
        .pc_src_i    (PCSrc),
        .pc_target_i (PCTarget),
        .pc_plus4_o  (PCPlus4),
        .pc_next_o   (pc_next)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_o  (misalign)
`endif
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Advance) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (misalign) state_d = TRAP;
                    else
`endif
                    begin
                        pc_d    = pc_next;
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            TRAP: state_d = TRAP;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = valid_q;
    assign PC         = pc_q;
    assign op         = instr_q[6:0];
    assign funct3     = instr_q[14:12];
    assign funct7b5   = instr_q[30];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign MisalignTrap = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fetch-address and instruction scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        Advance = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        MisalignTrap;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Advance     (Advance),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .MisalignTrap (MisalignTrap)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drops reset, checks the asynchronous response, releases on a falling clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_pc", PC, 32'h0);
        check("rst_valid", {31'b0, InstrValid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_instr", Instr, 32'h0000_0013);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_trap", {31'b0, MisalignTrap}, 32'd0);
`endif
        reset_n = 1'b1;
        check("boot_req", {31'b0, imem_req}, 32'd0);
        exp_pc = 32'h0;
        addr_q.delete();
        instr_q.delete();
        addr_q.push_back(32'h0);
    endtask

    task automatic do_fetch(input logic [31:0] data, input int waits, input bit poke);
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'b0, imem_req}, 32'd1);
        if (!imem_req || addr_q.size() == 0) return;
        exp_addr = addr_q.pop_front();
        check("fetch_addr", imem_addr, exp_addr);
        check("fetch_valid", {31'b0, InstrValid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            if (poke) begin
                Advance  = 1'b1;
                PCSrc    = 1'b1;
                PCTarget = 32'h80;
            end
            @(negedge clk);
            Advance = 1'b0;
            PCSrc   = 1'b0;
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_valid", {31'b0, InstrValid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        instr_q.push_back(data);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        exp_instr = instr_q.pop_front();
        check("valid_rise", {31'b0, InstrValid}, 32'd1);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("instr", Instr, exp_instr);
        check("op", {25'b0, op}, {25'b0, exp_instr[6:0]});
        check("funct3", {29'b0, funct3}, {29'b0, exp_instr[14:12]});
        check("funct7b5", {31'b0, funct7b5}, {31'b0, exp_instr[30]});
        check("pc", PC, exp_pc);
        check("pcplus4", PCPlus4, exp_pc + 32'd4);
    endtask

    task automatic advance(input bit src, input logic [31:0] tgt);
        Advance  = 1'b1;
        PCSrc    = src;
        PCTarget = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (!(src && tgt[1:0] != 2'b00))
`endif
        begin
            exp_pc = src ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
            addr_q.push_back(exp_pc);
        end
        @(negedge clk);
        Advance  = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        do_reset();
        @(negedge clk);
        check("req_after_boot", {31'b0, imem_req}, 32'd1);
        do_fetch(32'h0050_0093, 0, 1'b0);

        // Response outside FETCH must not disturb the held instruction.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("hold_instr", Instr, 32'h0050_0093);
        check("hold_valid", {31'b0, InstrValid}, 32'd1);
        check("hold_noreq", {31'b0, imem_req}, 32'd0);

        advance(1'b0, 32'h0);
        do_fetch(32'h4000_0033, 3, 1'b0);
        advance(1'b0, 32'h0);
        do_fetch(32'h0020_8113, 2, 1'b1);
        advance(1'b0, 32'h0);
        do_fetch(32'h0000_0063, 0, 1'b0);
        check("pc_12", PC, 32'd12);
        advance(1'b1, 32'h40);
        do_fetch(32'h0000_006F, 1, 1'b0);
        check("pc_40", PC, 32'h40);

        advance(1'b1, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0013, 0, 1'b0);
        advance(1'b0, 32'h0);
        do_fetch(32'h0000_0037, 0, 1'b0);
        check("pc_wrap", PC, 32'h0);

        advance(1'b1, 32'h20);
        check("mid_req", {31'b0, imem_req}, 32'd1);
        check("mid_addr", imem_addr, 32'h20);
        do_reset();
        @(negedge clk);
        do_fetch(32'h0000_0013, 0, 1'b0);

        advance(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            check("trap_flag", {31'b0, MisalignTrap}, 32'd1);
            check("trap_noreq", {31'b0, imem_req}, 32'd0);
            check("trap_pc", PC, 32'h0);
            @(negedge clk);
        end
`else
        do_fetch(32'h0000_0013, 0, 1'b0);
        check("mask_pc", PC, 32'h40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
